// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch_stage (master) and imem (slave).
// Request: a transfer happens on a rising edge where imem_req_valid && imem_req_ready; addr is held while valid && !ready.
interface fetch_stage_if #(
  parameter int DPW = 32
);
  logic           imem_req_valid;
  logic           imem_req_ready;
  logic [DPW-1:0] imem_req_addr;
  logic           imem_rsp_valid;
  logic [DPW-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: issues in-order imem requests, buffers {pc, instr} in a small queue for decode.
// Optional macro FETCH_PERF_EN adds saturating bubble/drop performance counters.
module fetch_stage #(
  parameter int             DPW       = 32,
  parameter logic [DPW-1:0] RESET_PC  = '0,
  parameter int             DEPTH     = 2,
  parameter logic [DPW-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stallF,
  input  logic           redirect,
  input  logic [DPW-1:0] redirect_pc,
  fetch_stage_if.master  imem,
  output logic [DPW-1:0] instrF,
  output logic [DPW-1:0] pcF,
  output logic           validF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]    perf_bubble_cnt,
  output logic [31:0]    perf_drop_cnt
`endif
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  // Wide enough for every response still in flight across any burst of redirects.
  localparam int             DCW     = 16;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

  // Instruction queue
  logic [DPW-1:0] q_pc    [DEPTH];
  logic [DPW-1:0] q_instr [DEPTH];
  logic [AW-1:0]  q_rd;
  logic [AW-1:0]  q_wr;
  logic [CW-1:0]  q_cnt;

  // PC tags of live (non-dropped) requests still awaiting a response
  logic [DPW-1:0] t_pc [DEPTH];
  logic [AW-1:0]  t_rd;
  logic [AW-1:0]  t_wr;
  logic [CW-1:0]  outstanding;

  logic [DPW-1:0] fetch_pc;
  logic [DCW-1:0] drop_cnt;

  logic [CW:0]    busy_sum;
  logic           req_valid_c;
  logic           accept;
  logic           rsp_keep;
  logic           rsp_drop;
  logic           pop;
  logic [DCW-1:0] drop_total;
  logic [DCW-1:0] drop_after_redirect;
  logic [DPW-1:0] redirect_target;

  always_comb begin
    busy_sum            = {1'b0, q_cnt} + {1'b0, outstanding};
    req_valid_c         = !rst && !redirect && (busy_sum < DEPTH_C);
    accept              = req_valid_c && imem.imem_req_ready;
    rsp_keep            = imem.imem_rsp_valid && !redirect && (drop_cnt == '0);
    rsp_drop            = imem.imem_rsp_valid && (redirect || (drop_cnt != '0));
    validF              = (q_cnt != '0);
    pop                 = validF && !stallF && !redirect;
    drop_total          = drop_cnt + DCW'(outstanding);
    drop_after_redirect = (imem.imem_rsp_valid && (drop_total != '0)) ?
                          drop_total - DCW'(1) : drop_total;
    redirect_target     = redirect_pc & ~(DPW'(3));
    instrF              = validF ? q_instr[q_rd] : NOP_INSTR;
    pcF                 = validF ? q_pc[q_rd] : '0;
  end

  assign imem.imem_req_valid = req_valid_c;
  assign imem.imem_req_addr  = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // Everything in flight becomes stale; the queue and tag FIFO restart empty.
      fetch_pc    <= redirect_target;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_after_redirect;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + DPW'(4);
        t_wr     <= t_wr + AW'(1);
      end
      if (rsp_keep) begin
        q_wr <= q_wr + AW'(1);
        t_rd <= t_rd + AW'(1);
      end
      if (pop) begin
        q_rd <= q_rd + AW'(1);
      end
      q_cnt       <= q_cnt + CW'(rsp_keep) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(rsp_keep);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - DCW'(1);
      end
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (accept) begin
      t_pc[t_wr] <= fetch_pc;
    end
    if (rsp_keep) begin
      q_pc[q_wr]    <= t_pc[t_rd];
      q_instr[q_wr] <= imem.imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_drop_cnt   <= '0;
    end else begin
      if (!validF && !stallF && !redirect && (perf_bubble_cnt != '1)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
      if (rsp_drop && (perf_drop_cnt != '1)) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: in-order memory model with variable latency plus a
// queue-based reference of what decode must see each cycle.
module tb_fetch_stage;
  localparam int          DPW      = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic        validF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  fetch_stage_if #(.DPW(DPW)) imem ();

  fetch_stage #(
    .DPW(DPW), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallF(stallF),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem(imem),
    .instrF(instrF),
    .pcF(pcF),
    .validF(validF)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct { logic [31:0] pc; logic [31:0] data; } qent_t;
  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] addr; int t; } pend_t;

  qent_t   exp_q[$];     // what decode should see, head first
  flight_t fl_q[$];      // requests the fetch stage should have issued, oldest first
  pend_t   mem_q[$];     // memory model: accepted requests and their response cycle
  logic [31:0] m_pc;
  int unsigned m_bub;
  int unsigned m_drp;
  int cyc;
  int last_t;
  int lat_min;
  int lat_max;
  int vectors;
  int miscompares;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_validF;
  logic [31:0] s_pcF;
  logic [31:0] s_instrF;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (fl_q[i]) if (!fl_q[i].stale) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered just after a rising edge with this cycle's inputs already driven.
  task automatic run_cycle();
    bit rv;
    bit e_req;
    bit e_valid;
    int t;
    flight_t f;
    rv = (mem_q.size() > 0) && (mem_q[0].t == cyc);
    imem.imem_rsp_valid = rv;
    imem.imem_rsp_data  = rv ? mem_f(mem_q[0].addr) : '0;
    @(negedge clk);
    e_valid = (exp_q.size() > 0);
    e_req   = !redirect && ((exp_q.size() + live_cnt()) < DEPTH);
    s_req_valid = imem.imem_req_valid;
    s_req_addr  = imem.imem_req_addr;
    s_validF    = validF;
    s_pcF       = pcF;
    s_instrF    = instrF;
    check("req_valid", 32'(imem.imem_req_valid), 32'(e_req));
    if (e_req) check("req_addr", imem.imem_req_addr, m_pc);
    check("validF", 32'(validF), 32'(e_valid));
    check("instrF", instrF, e_valid ? exp_q[0].data : NOP);
    check("pcF", pcF, e_valid ? exp_q[0].pc : 32'h0);
`ifdef FETCH_PERF_EN
    check("perf_bubble", perf_bubble_cnt, m_bub);
    check("perf_drop", perf_drop_cnt, m_drp);
    if (!e_valid && !stallF && !redirect) m_bub++;
`endif
    // memory side, driven by what the DUT actually did
    if (rv) void'(mem_q.pop_front());
    if (imem.imem_req_valid && imem.imem_req_ready) begin
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      mem_q.push_back('{addr: imem.imem_req_addr, t: t});
    end
    // reference update
    if (!redirect && e_valid && !stallF) void'(exp_q.pop_front());
    if (rv) begin
      check("rsp_has_request", 32'(fl_q.size() > 0), 32'd1);
      if (fl_q.size() > 0) begin
        f = fl_q.pop_front();
        if (!f.stale && !redirect) exp_q.push_back('{pc: f.pc, data: mem_f(f.pc)});
        else m_drp++;
      end
    end
    if (redirect) begin
      exp_q.delete();
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (e_req && imem.imem_req_ready) begin
      fl_q.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (exp_q.size() > DEPTH) begin
      miscompares++;
      $display("FAIL queue_overflow: %0d entries, limit %0d", exp_q.size(), DEPTH);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset at the current time; returns just after a rising edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    #1;
    check("rst_validF", 32'(validF), 32'd0);
    check("rst_instrF", instrF, NOP);
    check("rst_pcF", pcF, 32'h0);
    check("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_bubble", perf_bubble_cnt, 32'd0);
    check("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif
    exp_q.delete();
    fl_q.delete();
    mem_q.delete();
    m_pc   = RESET_PC;
    m_bub  = 0;
    m_drp  = 0;
    last_t = cyc;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      run_cycle();
      if (s_validF) seen = 1'b1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_pc"}, s_pcF, exp_pc);
      check({name, "_instr"}, s_instrF, mem_f(exp_pc));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit reached;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    last_t = 0;
    lat_min = 1;
    lat_max = 1;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    #1;
    do_reset();

    // Streaming from reset, 1-cycle memory
    imem.imem_req_ready = 1'b1;
    run_cycle();
    check("p1_addr0", s_req_addr, 32'h0);
    check("p1_valid0", 32'(s_validF), 32'd0);
    run_cycle();
    check("p1_addr1", s_req_addr, 32'h4);
    check("p1_valid1", 32'(s_validF), 32'd0);
    run_cycle();
    check("p1_valid2", 32'(s_validF), 32'd1);
    check("p1_pc2", s_pcF, 32'h0);
    run_cycle();
    check("p1_pc3", s_pcF, 32'h4);
    check("p1_instr3", s_instrF, mem_f(32'h4));

    // Stall with head at 0x8
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (exp_q.size() > 0 && exp_q[0].pc == 32'h8) reached = 1'b1;
      else run_cycle();
    end
    check("p2_reach", 32'(reached), 32'd1);
    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("p2_hold_pc", s_pcF, 32'h8);
      check("p2_hold_valid", 32'(s_validF), 32'd1);
    end
    check("p2_req_blocked", 32'(s_req_valid), 32'd0);
    stallF = 1'b0;
    run_cycle();
    check("p2_rel_pc8", s_pcF, 32'h8);
    run_cycle();
    check("p2_rel_pcC", s_pcF, 32'hC);

    // Redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (exp_q.size() == 0 && live_cnt() == 2) reached = 1'b1;
      else run_cycle();
    end
    check("p3_reach", 32'(reached), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    run_cycle();
    redirect = 1'b0;
    run_cycle();
    check("p3_flushed", 32'(s_validF), 32'd0);
    wait_first_valid("p3_first", 32'h100);

    // Redirect coinciding with a response and a ready memory
    lat_min = 1;
    lat_max = 1;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (mem_q.size() > 0 && mem_q[0].t == cyc) reached = 1'b1;
      else run_cycle();
    end
    check("p4_reach", 32'(reached), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    run_cycle();
    check("p4_req_valid", 32'(s_req_valid), 32'd0);
    redirect = 1'b0;
    wait_first_valid("p4_first", 32'h200);

    // Randomized traffic, including wrap of the fetch PC
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      stallF = ($urandom_range(9, 0) < 3);
      redirect = ($urandom_range(19, 0) == 0);
      if ($urandom_range(7, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else redirect_pc = $urandom & 32'h0000_FFFF;
      imem.imem_req_ready = ($urandom_range(9, 0) < 7);
      run_cycle();
    end
    stallF = 1'b0;
    redirect = 1'b0;

    // Memory refuses requests: decode sees bubbles
    imem.imem_req_ready = 1'b0;
    repeat (12) run_cycle();
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("p6_bubble_valid", 32'(s_validF), 32'd0);
      check("p6_bubble_instr", s_instrF, NOP);
    end

    // Asynchronous reset with the queue full
    imem.imem_req_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    stallF = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (exp_q.size() == DEPTH) reached = 1'b1;
      else run_cycle();
    end
    check("p7_full", 32'(reached), 32'd1);
    #2;
    do_reset();
    stallF = 1'b0;
    run_cycle();
    check("p7_restart_valid", 32'(s_req_valid), 32'd1);
    check("p7_restart_addr", s_req_addr, RESET_PC);
    wait_first_valid("p7_first", RESET_PC);
    repeat (10) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
